seq_detector_param: RTL and testbench



---
 rtl/seq_detector_param.sv | 117 +++++++++++
 tb/tb_seq_detector_param.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Purpose : serial pattern detector for a runtime-loadable PAT_W-bit pattern,
//           with overlapping or non-overlapping matching and a saturating counter.
// Latency : z pulses one cycle after the edge that samples the last pattern bit.
// Backpr. : none; a bit is consumed on every cycle with x_valid high, and gaps hold state.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   x_valid, x       qualified serial input bit
//   pat_load, pat_in load a new pattern (MSB = first bit in time)
//   overlap          1 = matches may share bits, 0 = restart after each match
//   cnt_clr          clear the match counter
//   z                registered one-cycle match pulse
//   cnt, cnt_sat     saturating match count and its all-ones flag
module seq_detector_param #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             x_valid,
   input  logic             x,
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_in,
   input  logic             overlap,
   input  logic             cnt_clr,
   output logic             z,
   output logic [CNT_W-1:0] cnt,
   output logic             cnt_sat
);

   // Fill count must reach PAT_W-1, so $clog2(PAT_W) bits are always enough.
   localparam int FC_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
   // Value of the fill count just before the bit that completes the history.
   localparam logic [FC_W-1:0] FILL_LAST = FC_W'(PAT_W - 2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t             state;
   logic [PAT_W-1:0]   pat_q;
   logic [PAT_W-2:0]   hist_q;
   logic [FC_W-1:0]    fill_q;

   logic [PAT_W-1:0]   cand;
   logic               take;
   logic               hit;
   logic [CNT_W-1:0]   cnt_nxt;

   // Candidate word: the held history with the new bit appended as LSB.
   // Its low PAT_W-1 bits are also the shifted history for the next cycle,
   // which keeps the shift valid for the minimum PAT_W of 2.
   assign cand = {hist_q, x};

   // A load in the same cycle discards the incoming bit; IDLE ignores input.
   assign take = x_valid && !pat_load && (state != IDLE);
   assign hit  = take && (state == RUN) && (cand == pat_q);

   // Clear beats a concurrent match; otherwise count up and stick at all ones.
   always_comb begin
      cnt_nxt = cnt;
      if (cnt_clr) begin
         cnt_nxt = '0;
      end else if (hit && (cnt != '1)) begin
         cnt_nxt = cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pat_q   <= '0;
         hist_q  <= '0;
         fill_q  <= '0;
         z       <= 1'b0;
         cnt     <= '0;
         cnt_sat <= 1'b0;
      end else begin
         z       <= hit;
         cnt     <= cnt_nxt;
         cnt_sat <= (cnt_nxt == '1);

         if (pat_load) begin
            // New pattern: nothing received under the old one may match it.
            pat_q  <= pat_in;
            hist_q <= '0;
            fill_q <= '0;
            state  <= FILL;
         end else if (take) begin
            case (state)
               FILL: begin
                  hist_q <= cand[PAT_W-2:0];
                  fill_q <= fill_q + FC_W'(1);
                  if (fill_q == FILL_LAST) begin
                     state <= RUN;
                  end
               end
               RUN: begin
                  if (hit && !overlap) begin
                     // Non-overlapping: drop every bit of this match.
                     hist_q <= '0;
                     fill_q <= '0;
                     state  <= FILL;
                  end else begin
                     hist_q <= cand[PAT_W-2:0];
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

   localparam int PAT_W = 4;

   logic       clk = 1'b0;
   logic       rst, x_valid, x, pat_load, overlap, cnt_clr;
   logic [3:0] pat_in;
   logic       z2, sat2, z8, sat8;
   logic [1:0] cnt2;
   logic [7:0] cnt8;

   int n_cmp = 0;
   int n_bad = 0;

   // Two instances on the same stimulus: a narrow counter to reach saturation
   // quickly and the default width.
   seq_detector_param #(.PAT_W(4), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .pat_load(pat_load),
      .pat_in(pat_in), .overlap(overlap), .cnt_clr(cnt_clr),
      .z(z2), .cnt(cnt2), .cnt_sat(sat2));

   seq_detector_param #(.PAT_W(4)) dut8 (
      .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .pat_load(pat_load),
      .pat_in(pat_in), .overlap(overlap), .cnt_clr(cnt_clr),
      .z(z8), .cnt(cnt8), .cnt_sat(sat8));

   always #5 clk = ~clk;

   // Reference model: list of bits received since the last load/restart.
   bit       m_loaded;
   int       m_pat;
   bit       m_bits[$];
   int       m_z, m_c2, m_c8;

   task automatic model_step(input logic r, xv, xx, pl, input logic [3:0] pin,
                             input logic ov, clr);
      int match = 0;
      if (r) begin
         m_loaded = 0; m_pat = 0; m_bits.delete();
         m_z = 0; m_c2 = 0; m_c8 = 0;
      end else begin
         if (pl) begin
            m_pat = pin; m_loaded = 1; m_bits.delete();
         end else if (xv && m_loaded) begin
            m_bits.push_back(xx);
            if (m_bits.size() >= PAT_W) begin
               int v = 0;
               for (int i = m_bits.size() - PAT_W; i < m_bits.size(); i++)
                  v = v * 2 + int'(m_bits[i]);
               if (v == m_pat) match = 1;
            end
            if (match && !ov) m_bits.delete();
            while (m_bits.size() > PAT_W - 1) void'(m_bits.pop_front());
         end
         m_z = match;
         if (clr) begin
            m_c2 = 0; m_c8 = 0;
         end else if (match) begin
            if (m_c2 < 3) m_c2++;
            if (m_c8 < 255) m_c8++;
         end
      end
   endtask

   task automatic drive(input logic r, xv, xx, pl, input logic [3:0] pin,
                        input logic ov, clr);
      rst = r; x_valid = xv; x = xx; pat_load = pl; pat_in = pin;
      overlap = ov; cnt_clr = clr;
      model_step(r, xv, xx, pl, pin, ov, clr);
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int ez, input int ec2, input int ec8);
      chk({tag, " z(w2)"}, int'(z2), ez);
      chk({tag, " z(w8)"}, int'(z8), ez);
      chk({tag, " cnt(w2)"}, int'(cnt2), ec2);
      chk({tag, " sat(w2)"}, int'(sat2), (ec2 == 3) ? 1 : 0);
      chk({tag, " cnt(w8)"}, int'(cnt8), ec8);
      chk({tag, " sat(w8)"}, int'(sat8), (ec8 == 255) ? 1 : 0);
   endtask

   task automatic chk_model(input string tag);
      chk_all(tag, m_z, m_c2, m_c8);
   endtask

   typedef struct {
      logic       r, xv, xx, pl;
      logic [3:0] pin;
      logic       ov, clr;
      int         ez, ec;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, xv, xx, pl, input logic [3:0] pin,
                      input logic ov, clr, input int ez, ec);
      vec_t v;
      v.r = r; v.xv = xv; v.xx = xx; v.pl = pl; v.pin = pin;
      v.ov = ov; v.clr = clr; v.ez = ez; v.ec = ec;
      tbl.push_back(v);
   endtask

   initial begin
      rst = 1'b1; x_valid = 1'b0; x = 1'b0; pat_load = 1'b0;
      pat_in = 4'h0; overlap = 1'b0; cnt_clr = 1'b0;

      //   r xv x pl pin  ov clr  z cnt
      // Overlapping, 1011 on 1,0,1,1,0,1,1
      add(1, 0, 0, 0, 4'h0, 1, 0, 0, 0);
      add(0, 0, 0, 1, 4'hB, 1, 0, 0, 0);
      add(0, 1, 1, 0, 4'h0, 1, 0, 0, 0);
      add(0, 1, 0, 0, 4'h0, 1, 0, 0, 0);
      add(0, 1, 1, 0, 4'h0, 1, 0, 0, 0);
      add(0, 1, 1, 0, 4'h0, 1, 0, 1, 1);
      add(0, 1, 0, 0, 4'h0, 1, 0, 0, 1);
      add(0, 1, 1, 0, 4'h0, 1, 0, 0, 1);
      add(0, 1, 1, 0, 4'h0, 1, 0, 1, 2);
      add(0, 0, 1, 0, 4'h0, 1, 0, 0, 2);
      // Non-overlapping, same stream; reload does not clear cnt, clr does
      add(0, 0, 0, 1, 4'hB, 0, 1, 0, 0);
      add(0, 1, 1, 0, 4'h0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 4'h0, 0, 0, 0, 0);
      add(0, 1, 1, 0, 4'h0, 0, 0, 0, 0);
      add(0, 1, 1, 0, 4'h0, 0, 0, 1, 1);
      add(0, 1, 0, 0, 4'h0, 0, 0, 0, 1);
      add(0, 1, 1, 0, 4'h0, 0, 0, 0, 1);
      add(0, 1, 1, 0, 4'h0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 4'h0, 0, 0, 0, 1);
      // No pattern loaded, then load concurrent with a valid bit
      add(1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
      add(0, 1, 1, 0, 4'h0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 4'h0, 0, 0, 0, 0);
      add(0, 1, 1, 0, 4'h0, 0, 0, 0, 0);
      add(0, 1, 1, 0, 4'h0, 0, 0, 0, 0);
      add(0, 1, 1, 1, 4'hB, 0, 0, 0, 0);
      add(0, 1, 0, 0, 4'h0, 0, 0, 0, 0);
      add(0, 1, 1, 0, 4'h0, 0, 0, 0, 0);
      add(0, 1, 1, 0, 4'h0, 0, 0, 0, 0);
      // Reset abandons a match in progress and forgets the pattern
      add(0, 0, 0, 1, 4'hB, 0, 0, 0, 0);
      add(0, 1, 1, 0, 4'h0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 4'h0, 0, 0, 0, 0);
      add(0, 1, 1, 0, 4'h0, 0, 0, 0, 0);
      add(0, 1, 1, 0, 4'h0, 0, 0, 1, 1);
      add(0, 1, 1, 0, 4'h0, 0, 0, 0, 1);
      add(0, 1, 0, 0, 4'h0, 0, 0, 0, 1);
      add(0, 1, 1, 0, 4'h0, 0, 0, 0, 1);
      add(1, 1, 1, 0, 4'h0, 0, 0, 0, 0);
      add(0, 1, 1, 0, 4'h0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 4'h0, 0, 0, 0, 0);
      add(0, 1, 1, 0, 4'h0, 0, 0, 0, 0);
      add(0, 1, 1, 0, 4'h0, 0, 0, 0, 0);

      foreach (tbl[i]) begin
         drive(tbl[i].r, tbl[i].xv, tbl[i].xx, tbl[i].pl, tbl[i].pin,
               tbl[i].ov, tbl[i].clr);
         chk_all($sformatf("vec%0d", i), tbl[i].ez, tbl[i].ec, tbl[i].ec);
      end

      // Gaps of three invalid cycles between bits do not break the sequence
      drive(1, 0, 0, 0, 4'h0, 1, 0);
      drive(0, 0, 0, 1, 4'hB, 1, 0);
      for (int i = 0; i < 4; i++) begin
         logic b;
         b = (i == 1) ? 1'b0 : 1'b1;
         drive(0, 1, b, 0, 4'h0, 1, 0);
         chk_all($sformatf("gap_bit%0d", i), (i == 3) ? 1 : 0, (i == 3) ? 1 : 0,
                 (i == 3) ? 1 : 0);
         for (int g = 0; g < 3; g++) begin
            drive(0, 0, ~b, 0, 4'h0, 1, 0);
            chk_all($sformatf("gap%0d_%0d", i, g), 0, (i == 3) ? 1 : 0,
                    (i == 3) ? 1 : 0);
         end
      end

      // All-zero pattern, overlapping: saturation and clear-vs-match
      drive(1, 0, 0, 0, 4'h0, 1, 0);
      drive(0, 0, 0, 1, 4'h0, 1, 0);
      for (int i = 1; i <= 8; i++) begin
         drive(0, 1, 0, 0, 4'h0, 1, 0);
         chk_all($sformatf("zeros_bit%0d", i), (i >= 4) ? 1 : 0,
                 (i >= 4) ? ((i - 3 > 3) ? 3 : i - 3) : 0,
                 (i >= 4) ? i - 3 : 0);
      end
      drive(0, 1, 0, 0, 4'h0, 1, 1);
      chk_all("clr_vs_match", 1, 0, 0);
      drive(0, 1, 0, 0, 4'h0, 1, 0);
      chk_all("after_clr", 1, 1, 1);

      // Run the wide counter into saturation
      for (int i = 0; i < 260; i++) begin
         drive(0, 1, 0, 0, 4'h0, 1, 0);
         chk_model($sformatf("sat_run%0d", i));
      end
      chk("sat_final cnt(w8)", int'(cnt8), 255);
      chk("sat_final sat(w8)", int'(sat8), 1);

      // Randomized traffic against the model
      drive(1, 0, 0, 0, 4'h0, 0, 0);
      chk_model("rnd_reset");
      for (int i = 0; i < 4000; i++) begin
         logic       r, xv, xx, pl, ov, clr;
         logic [3:0] pin;
         int         sel;
         r   = ($urandom_range(0, 299) == 0);
         pl  = ($urandom_range(0, 39) == 0);
         xv  = ($urandom_range(0, 9) < 7);
         xx  = 1'($urandom_range(0, 1));
         ov  = ((i / 500) % 2 == 0) ? ($urandom_range(0, 19) != 0)
                                    : ($urandom_range(0, 19) == 0);
         clr = ($urandom_range(0, 149) == 0);
         sel = $urandom_range(0, 3);
         pin = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hB : 4'($urandom_range(0, 15));
         drive(r, xv, xx, pl, pin, ov, clr);
         chk_model($sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
